// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks: frame geometry, the transmitter
// state encoding and a small parity helper.
// Ports: none (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Synchronous first-word-fall-through FIFO. The head entry is always
// visible on pop_data while the FIFO is non-empty. Pushes while full and
// pops while empty are ignored.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   push, push_data  write request and payload
//   pop             remove the head entry
//   pop_data        current head entry
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the index bits are equal.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; a simultaneous push and pop moves both pointers so the
  // occupancy is unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; stale entries are never visible past the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter: bytes queued through a FIFO are sent as 8N1 frames, or
// 8E1 when PARITY_EN is set. Each bit lasts max(div_i,1) clocks, with the
// divisor latched at frame start so a frame in flight is never disturbed.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   div_i         clock cycles per bit (0 treated as 1)
//   tx_valid_i    write request, accepted when tx_ready_o is high
//   tx_data_i     byte to send
//   tx_ready_o    FIFO not full
//   tx_o          serial line, idle high
//   busy_o        frame in progress or bytes still queued
//   fifo_cnt_o    FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter int DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DIV_W-1:0]              div_i,
  input  logic                          tx_valid_i,
  input  logic [7:0]                    tx_data_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);

  uart_tx_state_e            state;
  uart_tx_state_e            state_next;
  logic [DIV_W-1:0]          div_q;
  logic [DIV_W-1:0]          bit_cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [UART_DATA_BITS-1:0] pop_data;
  logic                      parity_q;
  logic                      tx_q;
  logic                      tx_next;
  logic                      pop;
  logic                      push;
  logic                      full;
  logic                      empty;
  logic                      bit_done;
  logic                      last_data_bit;

  assign push       = tx_valid_i && !full;
  assign tx_ready_o = !full;
  assign tx_o       = tx_q;
  assign busy_o     = (state != IDLE) || (fifo_cnt_o != '0);

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .push_data (tx_data_i),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (fifo_cnt_o)
  );

  // div_q is never zero, so div_q-1 is the last cycle of a bit period.
  assign bit_done      = (bit_cnt == div_q - DIV_W'(1));
  assign last_data_bit = (bit_idx == IDX_W'(UART_DATA_BITS - 1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state, pop request and next line level. The line is registered
  // from the current state, so tx_o trails the state by one clock; this
  // keeps every bit exactly div_q cycles wide on the pin.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx_next    = 1'b1;
    unique case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        tx_next = shreg[0];
        if (bit_done && last_data_bit) state_next = PARITY_EN ? PARITY : STOP;
      end
      PARITY: begin
        tx_next = parity_q;
        if (bit_done) state_next = STOP;
      end
      STOP: begin
        tx_next = 1'b1;
        // Chaining straight into the next start bit avoids an idle gap.
        if (bit_done) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: frame setup on pop, then bit-period counting and shifting.
  // Parity is captured at load time because shreg is consumed by shifting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_q     <= 1'b1;
      div_q    <= DIV_W'(1);
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      parity_q <= 1'b0;
    end else begin
      tx_q <= tx_next;
      if (pop) begin
        shreg    <= pop_data;
        parity_q <= even_parity(pop_data);
        div_q    <= (div_i == '0) ? DIV_W'(1) : div_i;
        bit_cnt  <= '0;
        bit_idx  <= '0;
      end else if (state != IDLE) begin
        if (bit_done) begin
          bit_cnt <= '0;
          if (state == DATA) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Drives an 8N1 instance (dut0) and an 8E1 instance (dut1). Every accepted
// byte is queued with the bit period it must be sent at; a per-instance
// line monitor decodes frames and compares them against the queue.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   div = 16'd4;
  logic [1:0]    tx_valid = 2'b00;
  logic [7:0]    tx_data = 8'h00;
  logic          ready0, ready1, tx0, tx1, busy0, busy1;
  logic [CW-1:0] cnt0, cnt1;

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   rst_count = 0;
  int   unexpected = 0;
  bit   mon_go = 1'b0;
  exp_t scb0[$];
  exp_t scb1[$];
  int   st0[$];
  int   st1[$];

  uart_tx #(.FIFO_DEPTH(DEPTH), .PARITY_EN(1'b0), .DIV_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .div_i(div), .tx_valid_i(tx_valid[0]),
    .tx_data_i(tx_data), .tx_ready_o(ready0), .tx_o(tx0), .busy_o(busy0),
    .fifo_cnt_o(cnt0)
  );

  uart_tx #(.FIFO_DEPTH(DEPTH), .PARITY_EN(1'b1), .DIV_W(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .div_i(div), .tx_valid_i(tx_valid[1]),
    .tx_data_i(tx_data), .tx_ready_o(ready1), .tx_o(tx1), .busy_o(busy1),
    .fifo_cnt_o(cnt1)
  );

  always #5 clk = ~clk;

  // Edge counter and reset-event counter, read by the processes at negedge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_count <= rst_count + 1;
  end

  function automatic logic line(input int which);
    return (which == 0) ? tx0 : tx1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Push one byte through the valid/ready handshake; the expected frame is
  // queued only when the handshake completes. Called and returns at negedge.
  task automatic applyStimulus(input int which, input logic [7:0] d,
                               input int exp_div, output int push_cyc);
    int   tries = 0;
    logic acc = 1'b0;
    exp_t e;
    tx_data = d;
    tx_valid[which] = 1'b1;
    while (!acc && tries < 5000) begin
      acc = (which == 0) ? ready0 : ready1;
      @(negedge clk);
      tries++;
    end
    tx_valid[which] = 1'b0;
    push_cyc = cyc;
    checkOutput($sformatf("push_accept%0d", which), {31'd0, acc}, 32'd1);
    if (acc) begin
      e.data = d;
      e.div  = exp_div;
      if (which == 0) scb0.push_back(e);
      else            scb1.push_back(e);
    end
  endtask

  task automatic wait_idle(input int which);
    int n = 0;
    while (((which == 0) ? busy0 : busy1) !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("idle_wait%0d", which), {31'd0, n < 5000}, 32'd1);
    repeat (20) @(negedge clk);
  endtask

  // Line monitor: on a start bit, pops the expected byte and checks every
  // cycle of the frame against the ideal waveform built from that byte.
  task automatic receive_frames(input int which);
    exp_t       e;
    logic [10:0] bits;
    logic [7:0] rx;
    logic       par_rx;
    int         nb, errs, base_rst, n;
    bit         aborted;
    bit         pen;
    pen = (which == 1);
    forever begin
      @(negedge clk);
      if (line(which) === 1'b0) begin
        if ((which == 0 && scb0.size() == 0) || (which == 1 && scb1.size() == 0)) begin
          unexpected++;
          $display("[TB] dut%0d start bit with nothing queued at cycle %0d", which, cyc);
          n = 0;
          while (line(which) !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
          end
        end else begin
          if (which == 0) begin
            e = scb0.pop_front();
            st0.push_back(cyc);
          end else begin
            e = scb1.pop_front();
            st1.push_back(cyc);
          end
          base_rst = rst_count;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[i+1] = e.data[i];
          if (pen) begin
            bits[9]  = ^e.data;
            bits[10] = 1'b1;
            nb = 11;
          end else begin
            bits[9]  = 1'b1;
            bits[10] = 1'b1;
            nb = 10;
          end
          errs = 0;
          aborted = 1'b0;
          rx = 8'h00;
          par_rx = 1'b0;
          for (int b = 0; b < nb && !aborted; b++) begin
            for (int c = 0; c < e.div; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst_count != base_rst) begin
                aborted = 1'b1;
                break;
              end
              if (line(which) !== bits[b]) errs++;
              if (c == e.div / 2) begin
                if (b >= 1 && b <= 8) rx[b-1] = line(which);
                if (pen && b == 9) par_rx = line(which);
              end
            end
          end
          if (!aborted) begin
            $display("[TB] dut%0d rx 0x%02h '%c'", which, rx, rx);
            checkOutput($sformatf("frame_data%0d", which), {24'd0, rx}, {24'd0, e.data});
            checkOutput($sformatf("frame_shape%0d", which), errs, 32'd0);
            if (pen) checkOutput("parity_bit", {31'd0, par_rx}, {31'd0, ^e.data});
          end
        end
      end
    end
  endtask

  initial begin
    wait (mon_go);
    receive_frames(0);
  end

  initial begin
    wait (mon_go);
    receive_frames(1);
  end

  initial begin
    int pc, e0, ok;
    logic [7:0] r;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx0", {31'd0, tx0}, 32'd1);
    checkOutput("rst_ready0", {31'd0, ready0}, 32'd1);
    checkOutput("rst_busy0", {31'd0, busy0}, 32'd0);
    checkOutput("rst_cnt0", {28'd0, cnt0}, 32'd0);
    checkOutput("rst_tx1", {31'd0, tx1}, 32'd1);
    checkOutput("rst_busy1", {31'd0, busy1}, 32'd0);
    rst = 1'b0;
    mon_go = 1'b1;
    @(negedge clk);

    // Single 0x55 at div 4: start bit appears two edges after the push.
    div = 16'd4;
    st0.delete();
    applyStimulus(0, 8'h55, 4, pc);
    wait_idle(0);
    checkOutput("latency", (st0.size() > 0) ? st0[0] - pc : -1, 32'd2);

    // Parity frame 0x07 at div 3.
    div = 16'd3;
    applyStimulus(1, 8'h07, 3, pc);
    wait_idle(1);

    // Nine bytes back to back: byte 0 is popped at once, eight stay queued.
    div = 16'd4;
    st0.delete();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(0, 8'(k), 4, pc);
      if (k == 0) e0 = pc;
    end
    checkOutput("full_cnt", {28'd0, cnt0}, 32'd8);
    checkOutput("full_ready", {31'd0, ready0}, 32'd0);
    tx_data = 8'hAA;
    tx_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    tx_valid[0] = 1'b0;
    checkOutput("held_off_cnt", {28'd0, cnt0}, 32'd8);
    while (cyc < e0 + 40) @(negedge clk);
    checkOutput("ready_before_pop", {31'd0, ready0}, 32'd0);
    @(negedge clk);
    checkOutput("ready_after_pop", {31'd0, ready0}, 32'd1);
    checkOutput("cnt_after_pop", {28'd0, cnt0}, 32'd7);
    wait_idle(0);
    ok = (st0.size() == 9);
    for (int i = 1; i < st0.size(); i++) if (st0[i] - st0[i-1] != 40) ok = 0;
    checkOutput("b2b_gap", ok, 32'd1);

    // div 0 acts as one cycle per bit.
    div = 16'd0;
    applyStimulus(0, 8'($urandom), 1, pc);
    wait_idle(0);

    // Divisor change mid-frame only affects the following frame.
    div = 16'd4;
    applyStimulus(0, 8'($urandom), 4, pc);
    repeat (10) @(negedge clk);
    div = 16'd8;
    applyStimulus(0, 8'($urandom), 8, pc);
    wait_idle(0);

    // Push coincident with the pop at the end of the first frame.
    div = 16'd4;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 8'($urandom), 4, pc);
      if (k == 0) e0 = pc;
    end
    while (cyc < e0 + 40) @(negedge clk);
    checkOutput("cnt_before_pushpop", {28'd0, cnt0}, 32'd3);
    r = 8'($urandom);
    applyStimulus(0, r, 4, pc);
    checkOutput("cnt_pushpop", {28'd0, cnt0}, 32'd3);
    wait_idle(0);

    // Reset during data bit 3 with two bytes queued.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 8'($urandom), 4, pc);
      if (k == 0) e0 = pc;
    end
    while (cyc < e0 + 17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    scb0.delete();
    checkOutput("midrst_tx", {31'd0, tx0}, 32'd1);
    checkOutput("midrst_cnt", {28'd0, cnt0}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy0}, 32'd0);
    repeat (150) @(negedge clk);
    checkOutput("postrst_busy", {31'd0, busy0}, 32'd0);

    // Random bursts on both instances.
    for (int w = 0; w < 2; w++) begin
      int d;
      d = $urandom_range(1, 5);
      div = 16'(d);
      repeat (6) begin
        applyStimulus(w, 8'($urandom), d, pc);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle(w);
    end

    checkOutput("scb0_drained", scb0.size(), 32'd0);
    checkOutput("scb1_drained", scb1.size(), 32'd0);
    checkOutput("unexpected_frames", unexpected, 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
